serial_add_sub_ctrl: RTL and testbench
======================================

Name: serial_add_sub_ctrl

Overview:
- Multi-cycle controller that sequences a single 1-bit add/subtract cell across WIDTH-bit operands, one bit per clock, LSB first.
- Captures operands on a start handshake and holds the carry/borrow in a flip-flop between bits.
- Presents the registered WIDTH-bit result and carry-out with a one-cycle done pulse.
- Used wherever area matters more than latency for N-bit add/subtract.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH), bit-index counter width (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse/level; accepted only in IDLE.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- mode  input  1  0 = A+B, 1 = A-B; sampled on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result/cout valid.
- result  output  WIDTH  registered sum/difference.
- cout  output  1  final carry; for subtract, 1 = no borrow (A>=B unsigned).

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (rst); it has priority over every other input.
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, counter=0, carry FF=0, shift regs=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge loads shift regs with a and (b XOR {WIDTH{mode}}), latches mode, sets carry FF=mode, counter=0, goes to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, each cycle:
  - bit cell sum = a_sr[0] ^ bsel_sr[0] ^ carry.
  - carry_next = majority(a_sr[0], bsel_sr[0], carry).
  - sum shifted into the result shift reg MSB side; operand regs shift right.
  - counter increments; at counter==WIDTH-1 the edge goes to DONE.
- SHIFT lasts exactly WIDTH cycles. busy=1 in SHIFT only.
- DONE:
  - On entry, result <= assembled shift reg and cout <= final carry.
  - done=1 for exactly this one cycle; next edge returns to IDLE.
- Latency: start accepted at edge k -> busy high cycles k+1..k+WIDTH -> done high cycle k+WIDTH+1. Throughput is one op per WIDTH+2 cycles.
- start while in SHIFT or DONE: ignored, no queuing. Operand changes after the accepting edge have no effect.
- start held high continuously: a new op is accepted on the first IDLE edge after each DONE.
- result/cout never show partial values. They hold the last completed op until the next DONE or reset.
- Arithmetic: modulo 2^WIDTH. Subtract is A + ~B + 1 (two's complement).
- Reset mid-SHIFT: abort, all regs to reset values, no done pulse; result/cout cleared to 0.

Optional Feature:
- Macro: SERIAL_ADD_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), registered in DONE alongside result.
  - ovf = carry into MSB XOR carry out of MSB (signed two's-complement overflow).
  - ovf holds until the next DONE or reset.
- Undefined: no ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, mode=0, start 1 cycle -> busy high 8 cycles, done pulse on the 9th cycle after the accepting edge, result=0x8D, cout=0.
- a=0xFF, b=0x01, mode=0 -> result=0x00, cout=1; with the macro defined, ovf=0. Then a=0x7F, b=0x01, mode=0 -> result=0x80, cout=0, ovf=1.
- a=0x10, b=0x01, mode=1 -> result=0x0F, cout=1. Then a=0x00, b=0x01, mode=1 -> result=0xFF, cout=0 (borrow).
- Accept a=0x05, b=0x03, mode=0. Pulse start at SHIFT cycle 3 with a=0xAA, b=0x55. Drive new operands on the inputs mid-op -> single done, result=0x08; no second op starts.
- Assert rst for 1 cycle during SHIFT cycle 4 -> next cycle busy=0, done=0, result=0x00, cout=0, state IDLE; a following start with a=0x02, b=0x02, mode=0 -> result=0x04 after normal latency.
- start held high with the same operands over 3 ops -> done pulses spaced exactly WIDTH+2 = 10 cycles apart, identical results each time.

Source files
------------

// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl
//
// Bit-serial add/subtract controller. It sequences one 1-bit full-adder cell
// across WIDTH-bit operands, one bit per clock and LSB first. The carry or
// borrow is held in a flip-flop between bits. A full operation takes WIDTH
// SHIFT cycles plus one DONE cycle.
//
// Ports:
//    clk     in   system clock, rising edge
//    rst     in   synchronous active-high reset, highest priority
//    start   in   request; accepted only in IDLE
//    a, b    in   WIDTH-bit operands, captured on the accepting edge
//    mode    in   0 = a+b, 1 = a-b, captured on the accepting edge
//    busy    out  high while bits are being processed
//    done    out  one-cycle pulse; result/cout valid
//    result  out  registered WIDTH-bit sum/difference
//    cout    out  final carry; for subtract, 1 = no borrow
//    ovf     out  signed overflow (only with SERIAL_ADD_SUB_OVF_EN)
//
// Build option: define SERIAL_ADD_SUB_OVF_EN to add the ovf output and its
// overflow logic.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; result/cout hold the last completed op
// SHIFT  | one operand bit per cycle through the add cell, WIDTH cycles
// DONE   | result/cout just updated; done pulses for this single cycle

module serial_add_sub_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_nxt;
   logic               load;
   logic               step;
   logic               last_bit;

   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   bsel_sr;
   logic [WIDTH-1:0]   res_sr;
   logic [WIDTH-1:0]   res_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic               bit_sum;
   logic               carry_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      last_bit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               last_bit  = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Single full-adder cell. Subtraction arrives here as a + ~b with
   // carry-in preset to 1, so the cell itself never looks at mode.
   always_comb begin
      bit_sum   = a_sr[0] ^ bsel_sr[0] ^ carry;
      carry_nxt = (a_sr[0] & bsel_sr[0]) | (a_sr[0] & carry) | (bsel_sr[0] & carry);
      res_nxt   = res_sr >> 1;
      res_nxt[WIDTH-1] = bit_sum;
   end

   // The captured mode lives on only as the initial carry and as the
   // inversion already folded into bsel_sr; nothing else needs it later.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr    <= '0;
         bsel_sr <= '0;
         res_sr  <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
         ovf     <= 1'b0;
`endif
      end else if (load) begin
         a_sr    <= a;
         bsel_sr <= b ^ {WIDTH{mode}};
         carry   <= mode;
         cnt     <= '0;
      end else if (step) begin
         a_sr    <= a_sr >> 1;
         bsel_sr <= bsel_sr >> 1;
         res_sr  <= res_nxt;
         carry   <= carry_nxt;
         cnt     <= cnt + CNT_W'(1);
         // Outputs are written only on the final bit, so partial sums are
         // never visible.
         if (last_bit) begin
            result <= res_nxt;
            cout   <= carry_nxt;
`ifdef SERIAL_ADD_SUB_OVF_EN
            // On the MSB, carry is the carry into the MSB.
            ovf    <= carry ^ carry_nxt;
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
module tb_serial_add_sub_ctrl;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mode;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
   logic             ovf;
`endif

   int checks;
   int errors;

   serial_add_sub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .mode   (mode),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
`ifdef SERIAL_ADD_SUB_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       vmode;
      logic [7:0] exp_res;
      logic       exp_cout;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Launch one op with a single-cycle start, scramble the inputs after the
   // accepting edge, and check busy length and done latency. Returns at the
   // negedge inside the done cycle.
   task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic im);
      int lat;
      int busy_cnt;
      @(negedge clk);
      a = ia; b = ib; mode = im; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~ia; b = ~ib; mode = ~im;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      chk("done_latency", lat, 9);
      chk("busy_cycles", busy_cnt, 8);
      chk("busy_in_done", {31'd0, busy}, 0);
   endtask

   initial begin
      int n_done;
      int t_done[4];
      logic [7:0] res_seen[4];
      logic restarted;

      checks = 0;
      errors = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0;

      vecs[0]  = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
      vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[3]  = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
      vecs[4]  = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[5]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[6]  = '{8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 1'b0};
      vecs[7]  = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};
      vecs[8]  = '{8'h55, 8'hAA, 1'b1, 8'hAB, 1'b0, 1'b1};
      vecs[9]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[10] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
      vecs[11] = '{8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy",   {31'd0, busy}, 0);
      chk("rst_done",   {31'd0, done}, 0);
      chk("rst_result", {24'd0, result}, 0);
      chk("rst_cout",   {31'd0, cout}, 0);

      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].va, vecs[i].vb, vecs[i].vmode);
         chk($sformatf("vec%0d_result", i), {24'd0, result}, {24'd0, vecs[i].exp_res});
         chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].exp_cout});
`ifdef SERIAL_ADD_SUB_OVF_EN
         chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
`endif
         @(negedge clk);
         chk($sformatf("vec%0d_done_width", i), {31'd0, done}, 0);
         chk($sformatf("vec%0d_hold", i), {24'd0, result}, {24'd0, vecs[i].exp_res});
      end

      // start pulsed mid-op with new operands must be ignored
      @(negedge clk);
      a = 8'h05; b = 8'h03; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      restarted = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (done) begin
            n_done++;
            chk("ignore_result", {24'd0, result}, 32'h08);
            chk("ignore_cout", {31'd0, cout}, 0);
         end
         if (n_done > 0 && busy) restarted = 1'b1;
         @(negedge clk);
      end
      chk("ignore_done_count", n_done, 1);
      chk("ignore_no_restart", {31'd0, restarted}, 0);

      // reset during SHIFT aborts, clears outputs, no done
      @(negedge clk);
      a = 8'h5A; b = 8'h33; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy",   {31'd0, busy}, 0);
      chk("abort_done",   {31'd0, done}, 0);
      chk("abort_result", {24'd0, result}, 0);
      chk("abort_cout",   {31'd0, cout}, 0);
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) n_done++;
         @(negedge clk);
      end
      chk("abort_quiet", n_done, 0);
      do_op(8'h02, 8'h02, 1'b0);
      chk("abort_next_result", {24'd0, result}, 32'h04);
      chk("abort_next_cout", {31'd0, cout}, 0);

      // start held high: back-to-back ops every WIDTH+2 cycles
      @(negedge clk);
      @(negedge clk);
      a = 8'h5A; b = 8'h33; mode = 1'b0; start = 1'b1;
      n_done = 0;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (done && n_done < 4) begin
            t_done[n_done] = i;
            res_seen[n_done] = result;
            n_done++;
         end
      end
      start = 1'b0;
      chk("held_done_count", n_done, 3);
      if (n_done >= 3) begin
         chk("held_first_latency", t_done[0], 8);
         chk("held_spacing_1", t_done[1] - t_done[0], 10);
         chk("held_spacing_2", t_done[2] - t_done[1], 10);
         for (int k = 0; k < 3; k++)
            chk($sformatf("held_result_%0d", k), {24'd0, res_seen[k]}, 32'h8D);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
